// File: rtl/cmd_parser_pkg.sv
// Shared definitions for the command parser: string ids, control character
// codes, printer state encoding, parser FSM states and byte classifiers.
package cmd_parser_pkg;

    localparam int MAX_LEN_DEF = 8;

    // String ids understood by the printer / string ROM
    localparam logic [1:0] ID_ERR  = 2'd0;
    localparam logic [1:0] ID_HELP = 2'd1;
    localparam logic [1:0] ID_PING = 2'd2;
    localparam logic [1:0] ID_LED  = 2'd3;

    // Control characters
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_DEL = 8'h7F;

    // Printer FSM encoding seen on printer_state
    localparam logic [1:0] PRN_IDLE = 2'd0;

    typedef enum logic [2:0] {
        ST_COLLECT   = 3'd0,
        ST_DROP      = 3'd1,
        ST_MATCH     = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    function automatic logic is_term(input logic [7:0] c);
        return (c == CH_CR) || (c == CH_LF);
    endfunction

    function automatic logic is_erase(input logic [7:0] c);
        return (c == CH_BS) || (c == CH_DEL);
    endfunction

    // Commands are case-insensitive, so letters are folded before storage
    function automatic logic [7:0] to_lower(input logic [7:0] c);
        if ((c >= 8'h41) && (c <= 8'h5A)) begin
            return c + 8'h20;
        end
        return c;
    endfunction

endpackage

// File: rtl/cmd_match.sv
// Combinational command matcher. Compares the stored line (length and every
// character) against the fixed command set and returns the string id.
// Expects MAX_LEN >= 4 so the longest command fits in the buffer.
module cmd_match
    import cmd_parser_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN*8-1:0] i_buf,
    input  logic [LEN_W-1:0]     i_len,
    output logic [1:0]           o_id
);

    // Command literals, first character in the most significant byte
    localparam logic [31:0] CMD_HELP = "help";
    localparam logic [31:0] CMD_PING = "ping";
    localparam logic [23:0] CMD_LED  = "led";

    logic [31:0] w_word4;
    logic [23:0] w_word3;

    // buf[0] is the first character typed; put it in the top byte
    assign w_word4 = {i_buf[7:0], i_buf[15:8], i_buf[23:16], i_buf[31:24]};
    assign w_word3 = w_word4[31:8];

    // Characters beyond the longest command never affect the match
    generate
        if (MAX_LEN > 4) begin : g_tail
            logic w_unused_tail;
            assign w_unused_tail = ^i_buf[MAX_LEN*8-1:32];
        end
    endgenerate

    // Exact match: length first, then all characters of that length
    always_comb begin
        o_id = ID_ERR;
        if ((i_len == LEN_W'(4)) && (w_word4 == CMD_HELP)) begin
            o_id = ID_HELP;
        end else if ((i_len == LEN_W'(4)) && (w_word4 == CMD_PING)) begin
            o_id = ID_PING;
        end else if ((i_len == LEN_W'(3)) && (w_word3 == CMD_LED)) begin
            o_id = ID_LED;
        end
    end

endmodule

// File: rtl/cmd_parser.sv
// Command parser: gathers UART RX bytes into a line buffer, matches completed
// lines against the command set, requests a response string from the printer
// and ignores input until the printer reports done. Owns the "led" LED.
module cmd_parser
    import cmd_parser_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [1:0] printer_state,
    input  logic       printer_done,
    output logic [1:0] str_id,
    output logic       print_enable,
    output logic       led,
    output logic       busy,
    output logic       overflow
);

    localparam int                LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(MAX_LEN);

    state_t               r_state;
    state_t               w_state_next;
    logic [LEN_W-1:0]     r_len;
    logic [7:0]           r_buf [MAX_LEN];
    logic [MAX_LEN*8-1:0] w_buf_flat;
    logic [1:0]           r_str_id;
    logic [1:0]           w_match_id;
    logic                 r_led;
    logic                 r_overflow;

    // FSM side effects decoded for the datapath registers
    logic w_store;
    logic w_erase;
    logic w_set_ovf;
    logic w_clr_ovf;
    logic w_load_match;
    logic w_load_err;
    logic w_clr_len;
    logic w_issue;

    cmd_match #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_match (
        .i_buf (w_buf_flat),
        .i_len (r_len),
        .o_id  (w_match_id)
    );

    // State register; reset aborts any line or print in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state actions; input is only accepted in COLLECT/DROP
    always_comb begin
        w_state_next = r_state;
        w_store      = 1'b0;
        w_erase      = 1'b0;
        w_set_ovf    = 1'b0;
        w_clr_ovf    = 1'b0;
        w_load_match = 1'b0;
        w_load_err   = 1'b0;
        w_clr_len    = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (rx_valid) begin
                    if (is_printable(rx_data)) begin
                        if (r_len == LEN_MAX) begin
                            w_set_ovf    = 1'b1;
                            w_state_next = ST_DROP;
                        end else begin
                            w_store = 1'b1;
                        end
                    end else if (is_erase(rx_data)) begin
                        w_erase = (r_len != '0);
                    end else if (is_term(rx_data)) begin
                        // Empty line (e.g. LF after CR) is not a command
                        if (r_len != '0) begin
                            w_state_next = ST_MATCH;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (rx_valid && is_term(rx_data)) begin
                    w_load_err   = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_MATCH: begin
                w_load_match = 1'b1;
                w_clr_ovf    = 1'b1;
                w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (printer_state == PRN_IDLE) begin
                    w_issue      = 1'b1;
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (printer_done) begin
                    w_clr_len    = 1'b1;
                    w_state_next = ST_COLLECT;
                end
            end
            default: begin
                w_state_next = ST_COLLECT;
            end
        endcase
    end

    // Line length, response id, LED and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_str_id   <= ID_ERR;
            r_led      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_clr_len) begin
                r_len <= '0;
            end else if (w_store) begin
                r_len <= r_len + LEN_W'(1);
            end else if (w_erase) begin
                r_len <= r_len - LEN_W'(1);
            end

            if (w_load_match) begin
                r_str_id <= w_match_id;
            end else if (w_load_err) begin
                r_str_id <= ID_ERR;
            end

            if (w_load_match && (w_match_id == ID_LED)) begin
                r_led <= ~r_led;
            end

            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end else if (w_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Line buffer write; contents beyond len are don't-care, so no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (w_store && (r_len == LEN_W'(i))) begin
                r_buf[i] <= to_lower(rx_data);
            end
        end
    end

    // Flatten the buffer for the matcher, character 0 in the low byte
    always_comb begin
        w_buf_flat = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_buf_flat[i*8 +: 8] = r_buf[i];
        end
    end

    assign str_id       = r_str_id;
    assign print_enable = w_issue;
    assign led          = r_led;
    assign busy         = (r_state != ST_COLLECT);
    assign overflow     = r_overflow;

endmodule
